// File: rtl/day10_pkg.sv
// Shared widths, FSM states and result record for the button-subset search
// that finds the fewest presses turning a machine's lights into its target.
package day10_pkg;

  function automatic int buttons_w(input int max_buttons);
    return (max_buttons <= 1) ? 1 : $clog2(max_buttons + 1);
  endfunction

  function automatic int lights_w(input int max_lights);
    return (max_lights <= 1) ? 1 : $clog2(max_lights + 1);
  endfunction

  localparam int RES_MAX_BUTTONS = 13;
  localparam int RES_PRESSES_W   = buttons_w(RES_MAX_BUTTONS);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  typedef struct packed {
    logic                       solvable;
    logic [RES_PRESSES_W-1:0]   presses;
    logic [RES_MAX_BUTTONS-1:0] mask;
  } result_t;

endpackage

// File: rtl/configure_machine_lane.sv
// One search lane: for a candidate subset, XORs the chosen button masks and
// reports range, raw target match and the subset's press count.
module configure_machine_lane
  import day10_pkg::*;
#(
  parameter  int MAX_NUM_LIGHTS    = 10,
  parameter  int MAX_NUM_BUTTONS   = 13,
  localparam int MAX_NUM_BUTTONS_W = buttons_w(MAX_NUM_BUTTONS)
) (
  input  logic [MAX_NUM_BUTTONS:0]                subset,
  input  logic [MAX_NUM_BUTTONS:0]                limit,
  input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] buttons,
  input  logic [MAX_NUM_LIGHTS-1:0]               target,
  output logic                                    in_range,
  output logic                                    hit,
  output logic [MAX_NUM_BUTTONS_W-1:0]            popcount
);

  logic [MAX_NUM_LIGHTS-1:0] acc;

  always_comb begin
    acc      = '0;
    popcount = '0;
    for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
      if (subset[b]) begin
        acc      = acc ^ buttons[b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS];
        popcount = popcount + MAX_NUM_BUTTONS_W'(1);
      end
    end
  end

  assign in_range = (subset < limit);
  assign hit      = (acc == target);

endmodule

// File: rtl/configure_machine_lanes.sv
// Exhaustive minimum-press search over all 2^nb button subsets, NUM_LANES
// subsets per cycle, with valid/ready handshakes on both sides.
module configure_machine_lanes
  import day10_pkg::*;
#(
  parameter  int MAX_NUM_LIGHTS    = 10,
  parameter  int MAX_NUM_BUTTONS   = 13,
  parameter  int NUM_LANES         = 4,
  localparam int MAX_NUM_BUTTONS_W = buttons_w(MAX_NUM_BUTTONS)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [MAX_NUM_LIGHTS-1:0]                 in_target,
  input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] in_buttons,
  input  logic [MAX_NUM_BUTTONS_W-1:0]              in_num_buttons,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_solvable,
  output logic [MAX_NUM_BUTTONS_W-1:0]              out_presses,
  output logic [MAX_NUM_BUTTONS-1:0]                out_mask
);

  localparam int BW  = MAX_NUM_BUTTONS * MAX_NUM_LIGHTS;
  localparam int SW  = MAX_NUM_BUTTONS + 1;

  state_t                       state, state_next;
  logic [SW-1:0]                base, limit;
  logic [MAX_NUM_BUTTONS_W-1:0] nb, nb_clamped;
  logic [MAX_NUM_BUTTONS_W-1:0] best, best_next;
  logic [MAX_NUM_BUTTONS-1:0]   best_mask, best_mask_next;
  logic [MAX_NUM_LIGHTS-1:0]    target_q;
  logic [BW-1:0]                buttons_q;
  logic                         accept, search_last, found, done;

  logic [NUM_LANES-1:0]         lane_in_range, lane_hit;
  logic [MAX_NUM_BUTTONS_W-1:0] lane_pop    [NUM_LANES];
  logic [SW-1:0]                lane_subset [NUM_LANES];

  assign limit      = SW'(1) << nb;
  assign nb_clamped = (in_num_buttons > MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS))
                      ? MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS) : in_num_buttons;
  assign accept     = in_valid && in_ready;
  // One extra bit so base + NUM_LANES cannot wrap before the compare.
  assign search_last = ({1'b0, base} + (SW+1)'(NUM_LANES)) >= {1'b0, limit};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_subset[l] = base + SW'(l);
    configure_machine_lane #(
      .MAX_NUM_LIGHTS  (MAX_NUM_LIGHTS),
      .MAX_NUM_BUTTONS (MAX_NUM_BUTTONS)
    ) u_lane (
      .subset   (lane_subset[l]),
      .limit    (limit),
      .buttons  (buttons_q),
      .target   (target_q),
      .in_range (lane_in_range[l]),
      .hit      (lane_hit[l]),
      .popcount (lane_pop[l])
    );
  end

  // Strict less-than keeps the lowest lane this cycle and earlier cycles' hits.
  always_comb begin
    best_next      = best;
    best_mask_next = best_mask;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_in_range[l] && lane_hit[l] && (lane_pop[l] < best_next)) begin
        best_next      = lane_pop[l];
        best_mask_next = lane_subset[l][MAX_NUM_BUTTONS-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_next = SEARCH;
      end
      SEARCH: begin
        if (search_last) state_next = DONE;
      end
      DONE: begin
        done = !rst;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      target_q  <= in_target;
      buttons_q <= in_buttons;
      nb        <= nb_clamped;
      base      <= '0;
      best      <= '1;
      best_mask <= '0;
    end else if (state == SEARCH) begin
      base      <= base + SW'(NUM_LANES);
      best      <= best_next;
      best_mask <= best_mask_next;
    end
  end

  assign found        = (best != '1);
  assign out_valid    = done;
  assign out_solvable = done && found;
  assign out_presses  = (done && found) ? best : '0;
  assign out_mask     = (done && found) ? best_mask : '0;

endmodule
